// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-port single-memory arbiter with starvation guard and read return tracking
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [3:0]  p0_wstrb,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [3:0]  p1_wstrb,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_we,
  input  logic [31:0] mem_rdata
);

  // A zero limit still needs a one-bit counter; it simply never leaves 0.
  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic          outstanding_q, outstanding_d;
  logic          owner_q, owner_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]   p0_rdata_q, p0_rdata_d;
  logic [31:0]   p1_rdata_q, p1_rdata_d;
  logic          p1_pri;
  logic          unused_addr_lsbs;

  assign unused_addr_lsbs = ^{p0_addr[1:0], p1_addr[1:0]};

  assign p1_pri = (wait_cnt_q == LIMIT);

  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (rst_n) begin
      if (p0_req && p1_req) begin
        p1_gnt = p1_pri;
        p0_gnt = ~p1_pri;
      end else begin
        p0_gnt = p0_req;
        p1_gnt = p1_req;
      end
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    mem_we    = 4'b0000;
    if (p0_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = {p0_addr[31:2], 2'b00};
      mem_wdata = p0_wdata;
      mem_we    = p0_we ? p0_wstrb : 4'b0000;
    end else if (p1_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = {p1_addr[31:2], 2'b00};
      mem_wdata = p1_wdata;
      mem_we    = p1_we ? p1_wstrb : 4'b0000;
    end
  end

  // Read data is forwarded straight from the memory in the return cycle and
  // held afterwards so a port's rdata only moves when its own read lands.
  assign p0_rvalid = rst_n & outstanding_q & ~owner_q;
  assign p1_rvalid = rst_n & outstanding_q & owner_q;
  assign p0_rdata  = p0_rvalid ? mem_rdata : p0_rdata_q;
  assign p1_rdata  = p1_rvalid ? mem_rdata : p1_rdata_q;

  always_comb begin
    outstanding_d = (p0_gnt & ~p0_we) | (p1_gnt & ~p1_we);
    owner_d       = p1_gnt;
    p0_rdata_d    = p0_rdata;
    p1_rdata_d    = p1_rdata;
    wait_cnt_d    = wait_cnt_q;
    if (!p1_req || p1_gnt) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != LIMIT) begin
      wait_cnt_d = wait_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outstanding_q <= 1'b0;
      owner_q       <= 1'b0;
      wait_cnt_q    <= '0;
      p0_rdata_q    <= 32'd0;
      p1_rdata_q    <= 32'd0;
    end else begin
      outstanding_q <= outstanding_d;
      owner_q       <= owner_d;
      wait_cnt_q    <= wait_cnt_d;
      p0_rdata_q    <= p0_rdata_d;
      p1_rdata_q    <= p1_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench with a cycle-level reference model for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int STARVE = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata, mem_rdata;
  logic [3:0]  p0_wstrb, p1_wstrb;
  logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, mem_en;
  logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_we;
  logic        f_p0_gnt, f_p0_rvalid, f_p1_gnt, f_p1_rvalid, f_mem_en;
  logic [31:0] f_p0_rdata, f_p1_rdata, f_mem_addr, f_mem_wdata;
  logic [3:0]  f_mem_we;

  int n_checks = 0;
  int n_fail   = 0;

  // model state: consecutive lost cycles of port 1, pending read owner (-1 none), last data per port
  int          m_wait = 0;
  int          m_pend = -1;
  logic [31:0] m_last [2] = '{32'd0, 32'd0};

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(STARVE)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_wstrb(p0_wstrb),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wstrb(p1_wstrb),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.STARVE_LIMIT(0)) u_fix (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_wstrb(p0_wstrb),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wstrb(p1_wstrb),
    .p0_gnt(f_p0_gnt), .p0_rvalid(f_p0_rvalid), .p0_rdata(f_p0_rdata),
    .p1_gnt(f_p1_gnt), .p1_rvalid(f_p1_rvalid), .p1_rdata(f_p1_rdata),
    .mem_en(f_mem_en), .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata), .mem_we(f_mem_we),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  function automatic int model_gnt();
    if (!rst_n) return -1;
    if (p0_req && p1_req) return (m_wait >= STARVE) ? 1 : 0;
    if (p0_req) return 0;
    if (p1_req) return 1;
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    g = model_gnt();
    if (!rst_n) begin
      m_wait = 0;
      m_pend = -1;
      m_last[0] = 32'd0;
      m_last[1] = 32'd0;
    end else begin
      if (m_pend >= 0) m_last[m_pend] = mem_rdata;
      if (g == 0 && !p0_we) m_pend = 0;
      else if (g == 1 && !p1_we) m_pend = 1;
      else m_pend = -1;
      if (p1_req && g != 1) m_wait = (m_wait < STARVE) ? m_wait + 1 : STARVE;
      else m_wait = 0;
    end
  end

  always @(negedge clk) begin
    int g;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_we;
    logic        e_rv0, e_rv1;
    g = model_gnt();
    e_addr = 32'd0; e_wdata = 32'd0; e_we = 4'b0000;
    if (g == 0) begin
      e_addr = p0_addr & 32'hFFFF_FFFC; e_wdata = p0_wdata; e_we = p0_we ? p0_wstrb : 4'b0000;
    end else if (g == 1) begin
      e_addr = p1_addr & 32'hFFFF_FFFC; e_wdata = p1_wdata; e_we = p1_we ? p1_wstrb : 4'b0000;
    end
    e_rv0 = rst_n && (m_pend == 0);
    e_rv1 = rst_n && (m_pend == 1);
    chk("m_p0_gnt", {31'd0, p0_gnt}, {31'd0, g == 0});
    chk("m_p1_gnt", {31'd0, p1_gnt}, {31'd0, g == 1});
    chk("m_mem_en", {31'd0, mem_en}, {31'd0, g >= 0});
    chk("m_mem_addr", mem_addr, e_addr);
    chk("m_mem_wdata", mem_wdata, e_wdata);
    chk("m_mem_we", {28'd0, mem_we}, {28'd0, e_we});
    chk("m_p0_rvalid", {31'd0, p0_rvalid}, {31'd0, e_rv0});
    chk("m_p1_rvalid", {31'd0, p1_rvalid}, {31'd0, e_rv1});
    chk("m_p0_rdata", p0_rdata, e_rv0 ? mem_rdata : m_last[0]);
    chk("m_p1_rdata", p1_rdata, e_rv1 ? mem_rdata : m_last[1]);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0; p0_wstrb = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0; p1_wstrb = 0;
  endtask

  initial begin
    rst_n = 0;
    idle();
    mem_rdata = 0;
    p0_req = 1;
    @(negedge clk);
    chk("rst_p0_gnt", {31'd0, p0_gnt}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_p0_rdata", p0_rdata, 32'd0);

    // lone p0 read
    next_cycle();
    rst_n = 1; idle();
    p0_req = 1; p0_addr = 32'h0000_1006;
    @(negedge clk);
    chk("rd0_gnt", {31'd0, p0_gnt}, 32'd1);
    chk("rd0_addr", mem_addr, 32'h0000_1004);
    chk("rd0_we", {28'd0, mem_we}, 32'd0);
    chk("fix_single_p0", {31'd0, f_p0_gnt}, 32'd1);
    next_cycle();
    idle(); mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rd0_rvalid", {31'd0, p0_rvalid}, 32'd1);
    chk("rd0_rdata", p0_rdata, 32'hDEAD_BEEF);
    chk("rd0_p1_rvalid", {31'd0, p1_rvalid}, 32'd0);
    next_cycle();
    mem_rdata = 0;
    @(negedge clk);
    chk("rd0_rvalid_once", {31'd0, p0_rvalid}, 32'd0);
    chk("rd0_rdata_hold", p0_rdata, 32'hDEAD_BEEF);

    // lone p1 write
    next_cycle();
    p1_req = 1; p1_we = 1; p1_addr = 32'h20; p1_wstrb = 4'b0011; p1_wdata = 32'h1234_1234;
    @(negedge clk);
    chk("wr1_gnt", {31'd0, p1_gnt}, 32'd1);
    chk("wr1_we", {28'd0, mem_we}, 32'h3);
    chk("wr1_wdata", mem_wdata, 32'h1234_1234);
    chk("wr1_addr", mem_addr, 32'h20);
    next_cycle();
    idle();
    @(negedge clk);
    chk("wr1_no_rv0", {31'd0, p0_rvalid}, 32'd0);
    chk("wr1_no_rv1", {31'd0, p1_rvalid}, 32'd0);

    // back-to-back reads from alternating ports
    next_cycle();
    p0_req = 1; p0_addr = 32'h40;
    @(negedge clk);
    chk("b2b_p0_gnt", {31'd0, p0_gnt}, 32'd1);
    next_cycle();
    idle(); p1_req = 1; p1_addr = 32'h80; mem_rdata = 32'hA;
    @(negedge clk);
    chk("b2b_p1_gnt", {31'd0, p1_gnt}, 32'd1);
    chk("b2b_rv0", {31'd0, p0_rvalid}, 32'd1);
    chk("b2b_rd0", p0_rdata, 32'hA);
    chk("b2b_rv1_early", {31'd0, p1_rvalid}, 32'd0);
    next_cycle();
    idle(); mem_rdata = 32'hB;
    @(negedge clk);
    chk("b2b_rv1", {31'd0, p1_rvalid}, 32'd1);
    chk("b2b_rd1", p1_rdata, 32'hB);
    chk("b2b_rv0_late", {31'd0, p0_rvalid}, 32'd0);
    chk("b2b_rd0_hold", p0_rdata, 32'hA);

    // continuous contention: p1 wins every ninth cycle
    next_cycle();
    mem_rdata = 32'h55;
    p0_req = 1; p0_addr = 32'h100; p1_req = 1; p1_addr = 32'h200;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      chk("starve_p1_gnt", {31'd0, p1_gnt}, {31'd0, (i % 9) == 8});
      chk("starve_p0_gnt", {31'd0, p0_gnt}, {31'd0, (i % 9) != 8});
      if (i == 0) begin
        chk("fix_p1_gnt", {31'd0, f_p1_gnt}, 32'd1);
        chk("fix_p0_gnt", {31'd0, f_p0_gnt}, 32'd0);
      end
      next_cycle();
    end
    idle();

    // interrupted wait restarts the count
    next_cycle();
    p0_req = 1; p1_req = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("intr_pre_p1", {31'd0, p1_gnt}, 32'd0);
      next_cycle();
    end
    p1_req = 0;
    @(negedge clk);
    chk("intr_gap_p0", {31'd0, p0_gnt}, 32'd1);
    next_cycle();
    p1_req = 1;
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      chk("intr_post_p1", {31'd0, p1_gnt}, {31'd0, j == 8});
      next_cycle();
    end
    idle();

    // reset while a read is outstanding
    next_cycle();
    p0_req = 1; p0_addr = 32'h300;
    @(negedge clk);
    chk("rstrd_gnt", {31'd0, p0_gnt}, 32'd1);
    #1 rst_n = 0;
    next_cycle();
    p1_req = 1; mem_rdata = 32'h77;
    @(negedge clk);
    chk("rstrd_rv0", {31'd0, p0_rvalid}, 32'd0);
    chk("rstrd_gnt0", {31'd0, p0_gnt}, 32'd0);
    chk("rstrd_gnt1", {31'd0, p1_gnt}, 32'd0);
    chk("rstrd_en", {31'd0, mem_en}, 32'd0);
    chk("rstrd_rd0", p0_rdata, 32'd0);
    chk("rstrd_rd1", p1_rdata, 32'd0);
    next_cycle();
    rst_n = 1; p1_req = 0; mem_rdata = 0;
    @(negedge clk);
    chk("rstrd_resume", {31'd0, p0_gnt}, 32'd1);
    chk("rstrd_no_stale", {31'd0, p0_rvalid}, 32'd0);
    next_cycle();
    idle(); mem_rdata = 32'hC0DE;
    @(negedge clk);
    chk("rstrd_new_rv", {31'd0, p0_rvalid}, 32'd1);
    chk("rstrd_new_rd", p0_rdata, 32'hC0DE);
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
